// File: rtl/phase_accumulator_pkg.sv
// Shared types and default widths for the NCO phase accumulator.
package phase_accumulator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned DEF_ACC_WIDTH   = 24;
    localparam int unsigned DEF_PHASE_WIDTH = 8;

endpackage

// File: rtl/phase_accumulator_if.sv
// Control, tuning-word handshake and phase output bundle of the phase accumulator.
interface phase_accumulator_if
    import phase_accumulator_pkg::*;
#(
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH
) ();

    logic                   start;
    logic                   stop;
    logic                   sync;
    logic [ACC_WIDTH-1:0]   ftw_data;
    logic                   ftw_valid;
    logic                   ftw_ready;
    logic [PHASE_WIDTH-1:0] phase_offset;
    logic [PHASE_WIDTH-1:0] phase;
    logic                   phase_valid;
    logic                   wrap;
    logic                   busy;

    modport master (
        output start, stop, sync, ftw_data, ftw_valid, phase_offset,
        input  ftw_ready, phase, phase_valid, wrap, busy
    );

    modport slave (
        input  start, stop, sync, ftw_data, ftw_valid, phase_offset,
        output ftw_ready, phase, phase_valid, wrap, busy
    );

endinterface

// File: rtl/phase_accumulator_ftw_shadow_reg.sv
// FTW shadow register: accepts a new tuning word and commits it to the accumulator
// either on the next cycle or only at a phase wrap / idle cycle.
module ftw_shadow_reg #(
    parameter int unsigned ACC_WIDTH      = 24,
    parameter bit          UPDATE_ON_WRAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ACC_WIDTH-1:0] ftw_data,
    input  logic                 ftw_valid,
    output logic                 ftw_ready,
    input  logic                 commit_en,
    output logic [ACC_WIDTH-1:0] ftw_active
);

    logic                 pending_q, pending_d;
    logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
    logic [ACC_WIDTH-1:0] active_q, active_d;
    logic                 commit;

    always_comb begin
        commit    = pending_q && (UPDATE_ON_WRAP ? commit_en : 1'b1);
        pending_d = pending_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        // ready is low while pending, so capture and commit are mutually exclusive
        if (commit) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (ftw_valid && !pending_q) begin
            shadow_d  = ftw_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
        end
    end

    assign ftw_ready  = !pending_q;
    assign ftw_active = active_q;

endmodule

// File: rtl/phase_accumulator.sv
// Phase accumulator (NCO core): acc += FTW each cycle, emits truncated+offset phase,
// with run/stop/drain control and glitch-free FTW updates.
module phase_accumulator
    import phase_accumulator_pkg::*;
#(
    parameter int unsigned ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int unsigned PHASE_WIDTH    = DEF_PHASE_WIDTH,
    parameter bit          UPDATE_ON_WRAP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    phase_accumulator_if.slave  bus
);

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic                   wrap_q, wrap_d;
    logic [ACC_WIDTH-1:0]   ftw_active;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   carry;
    logic                   commit_en;
    logic                   ftw_ready;

    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, ftw_active};
        acc_next = sum[ACC_WIDTH-1:0];
        carry    = sum[ACC_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (bus.stop) state_d = bus.sync ? ST_IDLE : ST_DRAIN;
            // a zero FTW never wraps, so draining would never end
            ST_DRAIN: if (ftw_active == '0 || (carry && !bus.sync)) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d   = '0;
        phase_d = bus.phase_offset;
        wrap_d  = (state_q != ST_IDLE) && !bus.sync && carry;
        if (state_q != ST_IDLE && state_d != ST_IDLE && !bus.sync) begin
            acc_d   = acc_next;
            phase_d = acc_next[ACC_WIDTH-1 -: PHASE_WIDTH] + bus.phase_offset;
        end
        commit_en = wrap_d || (state_q == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
        end
    end

    ftw_shadow_reg #(
        .ACC_WIDTH      (ACC_WIDTH),
        .UPDATE_ON_WRAP (UPDATE_ON_WRAP)
    ) u_ftw_shadow (
        .clk        (clk),
        .rst_n      (rst_n),
        .ftw_data   (bus.ftw_data),
        .ftw_valid  (bus.ftw_valid),
        .ftw_ready  (ftw_ready),
        .commit_en  (commit_en),
        .ftw_active (ftw_active)
    );

    assign bus.ftw_ready   = ftw_ready;
    assign bus.phase       = phase_q;
    assign bus.wrap        = wrap_q;
    assign bus.phase_valid = (state_q != ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: directed scenarios plus randomized
// traffic against a cycle-level arithmetic reference model.
module tb_phase_accumulator;

    localparam int unsigned AW = 24;
    localparam int unsigned PW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    phase_accumulator_if #(.ACC_WIDTH(AW), .PHASE_WIDTH(PW)) bus ();

    phase_accumulator #(
        .ACC_WIDTH      (AW),
        .PHASE_WIDTH    (PW),
        .UPDATE_ON_WRAP (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    longint unsigned m_acc, m_active, m_shadow;
    bit              m_run, m_drain, m_pending, m_wrap;
    logic [PW-1:0]   m_phase;

    function automatic void model_reset();
        m_acc = 0; m_active = 0; m_shadow = 0;
        m_run = 0; m_drain = 0; m_pending = 0; m_wrap = 0;
        m_phase = '0;
    endfunction

    function automatic void model_step();
        longint unsigned sum, nxt;
        bit was_idle, go_idle, wrapped, commit;
        sum      = m_acc + m_active;
        nxt      = sum % (64'd1 << AW);
        was_idle = !m_run && !m_drain;
        wrapped  = !was_idle && !bus.sync && (sum >= (64'd1 << AW));
        commit   = m_pending && (wrapped || was_idle);
        if (was_idle) begin
            if (bus.start) m_run = 1;
        end else if (m_run) begin
            if (bus.stop) begin m_run = 0; m_drain = !bus.sync; end
        end else if (m_active == 0 || wrapped) begin
            m_drain = 0;
        end
        go_idle = !m_run && !m_drain;
        if (was_idle || go_idle || bus.sync) begin
            m_acc = 0;
            m_phase = bus.phase_offset;
        end else begin
            m_acc = nxt;
            m_phase = PW'(nxt >> (AW - PW)) + bus.phase_offset;
        end
        m_wrap = wrapped;
        if (commit) begin
            m_active = m_shadow; m_pending = 0;
        end else if (bus.ftw_valid && !m_pending) begin
            m_shadow = bus.ftw_data; m_pending = 1;
        end
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start = 0; bus.stop = 0; bus.sync = 0;
        bus.ftw_data = '0; bus.ftw_valid = 0; bus.phase_offset = '0;
        rst_n = 0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic load_ftw(input logic [AW-1:0] v);
        bus.ftw_data = v; bus.ftw_valid = 1;
        tick();
        bus.ftw_valid = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.phase !== 8'h00) begin miscompares++; $display("FAIL reset_phase: got %h expected 00", bus.phase); end
        vectors++;
        if (bus.phase_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid_busy: got %b%b expected 00", bus.phase_valid, bus.busy);
        end
        vectors++;
        if (bus.wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b expected 0", bus.wrap); end
        vectors++;
        if (bus.ftw_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.ftw_ready); end
        bus.phase_offset = 8'h33;
        tick();
        vectors++;
        if (bus.phase !== 8'h33 || bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL idle_offset: phase=%h busy=%b expected 33 0", bus.phase, bus.busy);
        end
    endtask

    task automatic test_ramp();
        logic [PW-1:0] exp_p;
        logic exp_w;
        do_reset();
        load_ftw(24'h010000);
        bus.start = 1; tick(); bus.start = 0;
        for (int n = 1; n <= 257; n++) begin
            if (n > 1) tick();
            exp_p = PW'(n - 1);
            exp_w = (n == 257);
            vectors++;
            if (bus.phase !== exp_p || bus.wrap !== exp_w || bus.phase_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL ramp n=%0d: phase=%h wrap=%b valid=%b expected %h %b 1",
                         n, bus.phase, bus.wrap, bus.phase_valid, exp_p, exp_w);
            end
        end
    endtask

    task automatic test_half_scale();
        logic [PW-1:0] exp_p;
        logic exp_w;
        do_reset();
        load_ftw(24'h800000);
        bus.start = 1; tick(); bus.start = 0;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) tick();
            exp_p = (n % 2 == 0) ? 8'h80 : 8'h00;
            exp_w = (n > 1) && (n % 2 == 1);
            vectors++;
            if (bus.phase !== exp_p || bus.wrap !== exp_w) begin
                miscompares++;
                $display("FAIL half n=%0d: phase=%h wrap=%b expected %h %b", n, bus.phase, bus.wrap, exp_p, exp_w);
            end
        end
    endtask

    task automatic test_zero_ftw();
        do_reset();
        bus.phase_offset = 8'h40;
        load_ftw(24'h000000);
        bus.start = 1; tick(); bus.start = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) tick();
            vectors++;
            if (bus.phase !== 8'h40 || bus.phase_valid !== 1'b1 || bus.wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_ftw n=%0d: phase=%h valid=%b wrap=%b expected 40 1 0",
                         n, bus.phase, bus.phase_valid, bus.wrap);
            end
        end
        bus.stop = 1; tick(); bus.stop = 0;
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL zero_drain_busy: got %b expected 1", bus.busy); end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.phase !== 8'h40) begin
            miscompares++; $display("FAIL zero_drain_idle: busy=%b phase=%h expected 0 40", bus.busy, bus.phase);
        end
    endtask

    task automatic test_update_on_wrap();
        do_reset();
        load_ftw(24'h010000);
        bus.start = 1; tick(); bus.start = 0;
        repeat (16) tick();
        bus.ftw_data = 24'h020000; bus.ftw_valid = 1;
        tick();
        bus.ftw_valid = 0;
        vectors++;
        if (bus.phase !== 8'h11 || bus.ftw_ready !== 1'b0) begin
            miscompares++; $display("FAIL upd_capture: phase=%h ready=%b expected 11 0", bus.phase, bus.ftw_ready);
        end
        for (int p = 8'h12; p <= 8'hFF; p++) begin
            tick();
            vectors++;
            if (bus.phase !== PW'(p) || bus.ftw_ready !== 1'b0 || bus.wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL upd_hold p=%h: phase=%h ready=%b wrap=%b expected %h 0 0",
                         p, bus.phase, bus.ftw_ready, bus.wrap, PW'(p));
            end
        end
        tick();
        vectors++;
        if (bus.phase !== 8'h00 || bus.wrap !== 1'b1 || bus.ftw_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL upd_commit: phase=%h wrap=%b ready=%b expected 00 1 1", bus.phase, bus.wrap, bus.ftw_ready);
        end
        tick();
        vectors++;
        if (bus.phase !== 8'h02) begin miscompares++; $display("FAIL upd_step2a: got %h expected 02", bus.phase); end
        tick();
        vectors++;
        if (bus.phase !== 8'h04) begin miscompares++; $display("FAIL upd_step2b: got %h expected 04", bus.phase); end
    endtask

    task automatic test_stop_drain();
        do_reset();
        bus.phase_offset = 8'h05;
        load_ftw(24'h010000);
        bus.start = 1; tick(); bus.start = 0;
        repeat (128) tick();
        vectors++;
        if (bus.phase !== 8'h85) begin miscompares++; $display("FAIL stop_pre: got %h expected 85", bus.phase); end
        bus.stop = 1; tick(); bus.stop = 0;
        vectors++;
        if (bus.phase !== 8'h86 || bus.busy !== 1'b1) begin
            miscompares++; $display("FAIL stop_edge: phase=%h busy=%b expected 86 1", bus.phase, bus.busy);
        end
        for (int a = 8'h82; a <= 8'hFF; a++) begin
            if (a == 8'hA0) bus.start = 1;
            tick();
            bus.start = 0;
            vectors++;
            if (bus.phase !== PW'(a + 5) || bus.busy !== 1'b1 || bus.wrap !== 1'b0) begin
                miscompares++;
                $display("FAIL drain a=%h: phase=%h busy=%b wrap=%b expected %h 1 0",
                         a, bus.phase, bus.busy, bus.wrap, PW'(a + 5));
            end
        end
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.phase_valid !== 1'b0 || bus.wrap !== 1'b1 || bus.phase !== 8'h05) begin
            miscompares++;
            $display("FAIL drain_end: busy=%b valid=%b wrap=%b phase=%h expected 0 0 1 05",
                     bus.busy, bus.phase_valid, bus.wrap, bus.phase);
        end
        tick();
        vectors++;
        if (bus.wrap !== 1'b0 || bus.phase !== 8'h05) begin
            miscompares++; $display("FAIL drain_idle: wrap=%b phase=%h expected 0 05", bus.wrap, bus.phase);
        end
    endtask

    task automatic test_sync_stop();
        do_reset();
        bus.phase_offset = 8'h10;
        load_ftw(24'h010000);
        bus.start = 1; tick(); bus.start = 0;
        repeat (10) tick();
        vectors++;
        if (bus.phase !== 8'h1A) begin miscompares++; $display("FAIL sync_pre: got %h expected 1a", bus.phase); end
        bus.sync = 1; tick(); bus.sync = 0;
        vectors++;
        if (bus.phase !== 8'h10 || bus.busy !== 1'b1) begin
            miscompares++; $display("FAIL sync_run: phase=%h busy=%b expected 10 1", bus.phase, bus.busy);
        end
        tick();
        vectors++;
        if (bus.phase !== 8'h11) begin miscompares++; $display("FAIL sync_resume: got %h expected 11", bus.phase); end
        bus.stop = 1; bus.sync = 1; tick(); bus.stop = 0; bus.sync = 0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.phase !== 8'h10 || bus.wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_stop: busy=%b phase=%h wrap=%b expected 0 10 0", bus.busy, bus.phase, bus.wrap);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.phase_offset = 8'h00;
        load_ftw(24'h010000);
        bus.start = 1; tick(); bus.start = 0;
        repeat (30) tick();
        bus.ftw_data = 24'h030000; bus.ftw_valid = 1; tick(); bus.ftw_valid = 0;
        tick();
        #2;
        rst_n = 0;
        #1;
        vectors++;
        if (bus.phase !== 8'h00 || bus.phase_valid !== 1'b0 || bus.wrap !== 1'b0 ||
            bus.busy !== 1'b0 || bus.ftw_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: phase=%h valid=%b wrap=%b busy=%b ready=%b expected 00 0 0 0 1",
                     bus.phase, bus.phase_valid, bus.wrap, bus.busy, bus.ftw_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        load_ftw(24'h010000);
        bus.start = 1; tick(); bus.start = 0;
        vectors++;
        if (bus.phase !== 8'h00 || bus.phase_valid !== 1'b1) begin
            miscompares++; $display("FAIL restart_first: phase=%h valid=%b expected 00 1", bus.phase, bus.phase_valid);
        end
        tick();
        vectors++;
        if (bus.phase !== 8'h01) begin miscompares++; $display("FAIL restart_second: got %h expected 01", bus.phase); end
    endtask

    task automatic test_random();
        logic [PW+3:0] act, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.start = ($urandom_range(3) == 0);
            bus.stop  = ($urandom_range(39) == 0);
            bus.sync  = ($urandom_range(99) == 0);
            bus.ftw_valid = ($urandom_range(9) == 0);
            bus.ftw_data  = ($urandom_range(7) == 0) ? '0 : AW'($urandom());
            if ($urandom_range(63) == 0) bus.phase_offset = PW'($urandom());
            tick();
            act = {bus.phase, bus.wrap, bus.phase_valid, bus.busy, bus.ftw_ready};
            exp = {m_phase, m_wrap, m_run | m_drain, m_run | m_drain, !m_pending};
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL random i=%0d: {phase,wrap,valid,busy,ready}=%h expected %h", i, act, exp);
            end
        end
        bus.start = 0; bus.stop = 0; bus.sync = 0; bus.ftw_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp();
        test_half_scale();
        test_zero_ftw();
        test_update_on_wrap();
        test_stop_drain();
        test_sync_stop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
